// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM state encoding and
// the millisecond-to-clock-cycle conversion.
package button_debounce_pkg;

    localparam int MS_PER_S = 1000;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

    function automatic int ms_to_cycles(input int osc_f, input int ms);
        return osc_f / MS_PER_S * ms;
    endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RESET_VAL so the output is a defined level straight out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking (<=) so both flops sample the
    // pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push-button and reports the level, press/release/
// long-press strobes and a wrapping press counter, all from registers.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int OSC_F       = 24_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DB_CYCLES   = ms_to_cycles(OSC_F, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(OSC_F, LONG_MS);
    localparam int DB_W        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              w_b_s;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DB_W-1:0]   r_db_cnt;
    logic [DB_W-1:0]   w_db_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_press_evt;
    logic              w_release_evt;
    logic              r_pressed;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_long_pulse;
    logic [7:0]        r_press_count;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (button),
        .o_q (w_b_s)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_db_nxt      = r_db_cnt;
        w_press_evt   = 1'b0;
        w_release_evt = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (!w_b_s) begin
                    w_state_nxt = ST_PRESS_PEND;
                    w_db_nxt    = DB_W'(1);
                end
            end
            ST_PRESS_PEND: begin
                if (w_b_s) begin
                    w_state_nxt = ST_RELEASED;
                    w_db_nxt    = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_db_nxt    = '0;
                    w_press_evt = 1'b1;
                end else begin
                    w_db_nxt = r_db_cnt + DB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (w_b_s) begin
                    w_state_nxt = ST_RELEASE_PEND;
                    w_db_nxt    = DB_W'(1);
                end
            end
            ST_RELEASE_PEND: begin
                if (!w_b_s) begin
                    w_state_nxt = ST_PRESSED;
                    w_db_nxt    = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = ST_RELEASED;
                    w_db_nxt      = '0;
                    w_release_evt = 1'b1;
                end else begin
                    w_db_nxt = r_db_cnt + DB_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_db_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_RELEASED;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_db_cnt        <= w_db_nxt;
            r_pressed       <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_PEND);
            r_press_pulse   <= w_press_evt;
            r_release_pulse <= w_release_evt;
            if (w_press_evt)
                r_press_count <= r_press_count + 8'd1;

            // A release glitch returns to PRESSED without clearing the hold time.
            if (w_press_evt)
                r_hold_cnt <= '0;
            else if (r_pressed && (r_hold_cnt != HOLD_MAX))
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);

            // Saturation makes HOLD_LAST a one-shot; a completing release suppresses it.
            r_long_pulse <= r_pressed && (r_hold_cnt == HOLD_LAST) && !w_release_evt;
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign press_count   = r_press_count;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at OSC_F=10k, 1 ms debounce (10 cycles),
// 5 ms long press (50 cycles).
module tb_button_debounce;

    logic       clk;
    logic       rst;
    logic       button;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int n_press   = 0;
    int n_release = 0;
    int n_long    = 0;
    int n_coinc   = 0;
    int press_cyc   = -1;
    int release_cyc = -1;
    int long_cyc    = -1;

    button_debounce #(
        .OSC_F      (10_000),
        .DEBOUNCE_MS(1),
        .LONG_MS    (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press_pulse) begin
            n_press   = n_press + 1;
            press_cyc = cyc;
        end
        if (release_pulse) begin
            n_release   = n_release + 1;
            release_cyc = cyc;
        end
        if (long_pulse) begin
            n_long   = n_long + 1;
            long_cyc = cyc;
        end
        if ((press_pulse && release_pulse) || (long_pulse && release_pulse))
            n_coinc = n_coinc + 1;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        button = 1'b1;
        rst    = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(2);
    endtask

    task automatic test_reset();
        button = 1'b0;
        wait_n(3);
        n_checks++;
        if ({pressed, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {pressed, press_pulse, release_pulse, long_pulse});
        end
        n_checks++;
        if (press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", press_count);
        end
        button = 1'b1;
        rst    = 1'b0;
        wait_n(2);
    endtask

    task automatic test_clean_press();
        int d, r, s_p, s_l, s_r;
        do_reset();
        s_p = n_press; s_l = n_long; s_r = n_release;
        button = 1'b0;
        d = cyc;
        wait_n(11);
        n_checks++;
        if ({pressed, press_pulse} !== 2'b00) begin
            n_fail++;
            $display("FAIL clean_early: pressed/pulse got %b expected 00 at edge N+10",
                     {pressed, press_pulse});
        end
        wait_n(1);
        n_checks++;
        if ({pressed, press_pulse, press_count} !== {2'b11, 8'd1}) begin
            n_fail++;
            $display("FAIL clean_press: pressed=%b pulse=%b count=%0d expected 1 1 1",
                     pressed, press_pulse, press_count);
        end
        wait_n(1);
        n_checks++;
        if (press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_pulse_width: pulse got %b expected 0", press_pulse);
        end
        wait_n(27);
        button = 1'b1;
        r = cyc;
        wait_n(20);
        n_checks++;
        if (n_long - s_l != 0) begin
            n_fail++;
            $display("FAIL clean_no_long: long pulses got %0d expected 0", n_long - s_l);
        end
        n_checks++;
        if (n_press - s_p != 1 || press_cyc != d + 12) begin
            n_fail++;
            $display("FAIL clean_press_time: count %0d at +%0d expected 1 at +12",
                     n_press - s_p, press_cyc - d);
        end
        n_checks++;
        if (n_release - s_r != 1 || release_cyc != r + 12 || pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release: count %0d at +%0d pressed=%b expected 1 at +12 pressed=0",
                     n_release - s_r, release_cyc - r, pressed);
        end
    endtask

    task automatic test_bounce();
        int s_p, s_l, s_r;
        do_reset();
        s_p = n_press; s_l = n_long; s_r = n_release;
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0) ? 1'b0 : 1'b1;
            wait_n(4);
        end
        button = 1'b1;
        wait_n(20);
        n_checks++;
        if ((n_press - s_p) + (n_release - s_r) + (n_long - s_l) != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d/%0d/%0d expected 0/0/0",
                     n_press - s_p, n_release - s_r, n_long - s_l);
        end
        n_checks++;
        if (pressed !== 1'b0 || press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL bounce_state: pressed=%b count=%0d expected 0 0", pressed, press_count);
        end
    endtask

    task automatic test_long_press();
        int d, r, s_p, s_l, s_r;
        do_reset();
        s_p = n_press; s_l = n_long; s_r = n_release;
        button = 1'b0;
        d = cyc;
        wait_n(80);
        button = 1'b1;
        r = cyc;
        wait_n(20);
        n_checks++;
        if (n_press - s_p != 1 || press_cyc != d + 12) begin
            n_fail++;
            $display("FAIL long_press_time: count %0d at +%0d expected 1 at +12",
                     n_press - s_p, press_cyc - d);
        end
        n_checks++;
        if (n_long - s_l != 1 || long_cyc != press_cyc + 50) begin
            n_fail++;
            $display("FAIL long_pulse: count %0d at press+%0d expected 1 at press+50",
                     n_long - s_l, long_cyc - press_cyc);
        end
        n_checks++;
        if (n_release - s_r != 1 || release_cyc != r + 12) begin
            n_fail++;
            $display("FAIL long_release: count %0d at +%0d expected 1 at +12",
                     n_release - s_r, release_cyc - r);
        end
    endtask

    task automatic test_release_glitch();
        int d, r, s_l, s_r;
        logic dropped;
        do_reset();
        s_l = n_long; s_r = n_release;
        dropped = 1'b0;
        button = 1'b0;
        d = cyc;
        wait_n(20);
        button = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_n(1);
            if (pressed !== 1'b1) dropped = 1'b1;
        end
        button = 1'b0;
        for (int i = 0; i < 55; i++) begin
            wait_n(1);
            if (pressed !== 1'b1) dropped = 1'b1;
        end
        n_checks++;
        if (dropped !== 1'b0 || n_release - s_r != 0) begin
            n_fail++;
            $display("FAIL glitch_hold: dropped=%b releases=%0d expected 0 0",
                     dropped, n_release - s_r);
        end
        button = 1'b1;
        r = cyc;
        wait_n(20);
        n_checks++;
        if (n_long - s_l != 1 || long_cyc != d + 62) begin
            n_fail++;
            $display("FAIL glitch_long: count %0d at +%0d expected 1 at +62",
                     n_long - s_l, long_cyc - d);
        end
        n_checks++;
        if (n_release - s_r != 1 || release_cyc != r + 12) begin
            n_fail++;
            $display("FAIL glitch_release: count %0d at +%0d expected 1 at +12",
                     n_release - s_r, release_cyc - r);
        end
    endtask

    task automatic test_wrap();
        int s_p;
        do_reset();
        s_p = n_press;
        for (int i = 0; i < 255; i++) begin
            button = 1'b0;
            wait_n(14);
            button = 1'b1;
            wait_n(14);
        end
        n_checks++;
        if (press_count !== 8'd255 || n_press - s_p != 255) begin
            n_fail++;
            $display("FAIL wrap_255: count=%0d pulses=%0d expected 255 255",
                     press_count, n_press - s_p);
        end
        button = 1'b0;
        wait_n(12);
        n_checks++;
        if (press_pulse !== 1'b1 || press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_256: pulse=%b count=%0d expected 1 0", press_pulse, press_count);
        end
        wait_n(2);
        button = 1'b1;
        wait_n(14);
    endtask

    task automatic test_reset_mid_press();
        int d, s_p, s_r;
        do_reset();
        button = 1'b0;
        wait_n(20);
        s_p = n_press; s_r = n_release;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pressed, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: pressed=%b pulses=%b%b%b count=%0d expected all 0",
                     pressed, press_pulse, release_pulse, long_pulse, press_count);
        end
        wait_n(3);
        rst = 1'b0;
        d = cyc;
        wait_n(20);
        n_checks++;
        if (n_press - s_p != 1 || press_cyc != d + 12 || press_count !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_repress: count %0d at +%0d total=%0d expected 1 at +12 total=1",
                     n_press - s_p, press_cyc - d, press_count);
        end
        n_checks++;
        if (n_release - s_r != 0) begin
            n_fail++;
            $display("FAIL midrst_no_release: got %0d expected 0", n_release - s_r);
        end
        button = 1'b1;
        wait_n(20);
    endtask

    task automatic test_no_overlap();
        n_checks++;
        if (n_coinc != 0) begin
            n_fail++;
            $display("FAIL overlap: coinciding pulse cycles got %0d expected 0", n_coinc);
        end
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_wrap();
        test_reset_mid_press();
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter OSC_F, default 24_000_000, clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 20, time the input must hold a new level before it is accepted.
REQ-003 Parameter LONG_MS, default 1000, hold time after which a press counts as a long press.
REQ-004 clk  input  1  single clock; all state in this one domain.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 button  input  1  raw board push-button, active-low (0 = pressed), asynchronous to clk, may bounce.
REQ-007 pressed  output  1  debounced button level, active-high (1 = pressed).
REQ-008 press_pulse  output  1  one-cycle strobe on an accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on an accepted release.
REQ-010 long_pulse  output  1  one-cycle strobe when a press has lasted LONG_MS.
REQ-011 press_count  output  8  count of accepted presses, wraps 255 -> 0.

Function
REQ-012 DB_CYCLES SHALL be OSC_F/1000*DEBOUNCE_MS, LONG_CYCLES SHALL be OSC_F/1000*LONG_MS, and counter widths SHALL come from $clog2 of these values.
REQ-013 button SHALL pass through a 2-flop synchronizer whose flops reset to 1 (released); b_s is the second flop.
REQ-014 FSM states SHALL be RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND; reset state is RELEASED.
REQ-015 RELEASED: b_s=0 -> PRESS_PEND with db_cnt=1; otherwise stay.
REQ-016 PRESS_PEND: b_s=1 -> RELEASED, db_cnt=0 (bounce rejected, no pulse); b_s=0 and db_cnt==DB_CYCLES-1 -> PRESSED; otherwise db_cnt+1.
REQ-017 PRESSED: b_s=1 -> RELEASE_PEND with db_cnt=1; otherwise stay.
REQ-018 RELEASE_PEND: b_s=0 -> PRESSED, db_cnt=0, no pulse, hold counter not cleared; b_s=1 and db_cnt==DB_CYCLES-1 -> RELEASED; otherwise db_cnt+1.
REQ-019 Latency: if edge N first loads 0 into the first synchronizer flop and button stays low, the PRESSED transition SHALL be registered at edge N+DB_CYCLES+1; release is symmetric.
REQ-020 pressed SHALL be 1 in PRESSED and RELEASE_PEND, 0 otherwise, changing on the same edge as the press/release pulse.
REQ-021 press_pulse SHALL be high for exactly the cycle after the PRESS_PEND->PRESSED edge; release_pulse likewise for RELEASE_PEND->RELEASED.
REQ-022 press_count SHALL increment on the same edge that sets press_pulse.
REQ-023 hold_cnt SHALL clear on entry to PRESSED from PRESS_PEND, increment each cycle while pressed=1, and saturate at LONG_CYCLES.
REQ-024 long_pulse SHALL fire once per press, in the cycle after hold_cnt reaches LONG_CYCLES-1; holding longer SHALL NOT fire it again.
REQ-025 Pulses SHALL be registered outputs: no combinational path from button to any output.
REQ-026 A press and a release SHALL never pulse in the same cycle; long_pulse and release_pulse SHALL never coincide.

Reset
REQ-027 While rst=1: state RELEASED, db_cnt=0, hold_cnt=0, synchronizer flops=1, pressed=0, all pulses 0, press_count=0.
REQ-028 Reset asserted mid-press SHALL drop pressed without generating release_pulse; after reset releases, a still-held button SHALL go through full debounce and produce one press_pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the ms-to-cycles conversion constant (1000).
REQ-030 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a reset-value parameter.

Verification (OSC_F=10_000, DEBOUNCE_MS=1 -> DB_CYCLES=10, LONG_MS=5 -> LONG_CYCLES=50)
REQ-031 Clean press: button 1->0 held -> press_pulse at edge N+11, pressed=1, press_count=1, no long_pulse before 50 held cycles.
REQ-032 Bounce: button toggles low/high every 4 cycles for 40 cycles, then stays high -> no pulses, pressed=0, press_count=0.
REQ-033 Long press: hold low for 80 cycles -> exactly one long_pulse 50 cycles after press_pulse, then release_pulse 11 cycles after release.
REQ-034 Release glitch: while pressed, raise button for 5 cycles -> no release_pulse, pressed stays 1, long_pulse timing unchanged.
REQ-035 Wrap: 256 clean presses -> press_count returns to 0 on the 256th press_pulse.
REQ-036 Reset mid-press: assert rst while pressed with button held -> outputs 0 immediately, no release_pulse; after rst deasserts, press_pulse occurs 11 cycles later.
